// File: rtl/vc_fifo_arb.sv
// Two-VC input FIFO pair with a single-pop arbiter and registered pop strobes.
// Define VC_ARB_ROUND_ROBIN_EN for round-robin arbitration; strict VC0 priority otherwise.
module vc_fifo_arb #(
  parameter int BITNUMBER = 5,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 valid_in,
  input  logic                 pause,
  output logic                 valid_VC0,
  output logic                 valid_VC1,
  output logic [BITNUMBER-1:0] data_out0,
  output logic [BITNUMBER-1:0] data_out1,
  output logic                 vc0_full,
  output logic                 vc1_full,
  output logic                 vc0_empty,
  output logic                 vc1_empty,
  output logic                 error
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [BITNUMBER-1:0] mem    [2][DEPTH];
  logic [PW-1:0]        wr_ptr [2];
  logic [PW-1:0]        rd_ptr [2];
  logic [CW-1:0]        count  [2];
  logic [BITNUMBER-1:0] head   [2];
  logic [1:0]           full;
  logic [1:0]           empty;
  logic [1:0]           pop;
  logic [1:0]           push;
  logic                 push_vc;
  logic                 overflow;

`ifdef VC_ARB_ROUND_ROBIN_EN
  typedef enum logic {LAST_VC0, LAST_VC1} last_e;
  last_e last_served;
`endif

  assign push_vc = data_in[BITNUMBER-1];

  always_comb begin
    pop = '0;
    if (!pause) begin
`ifdef VC_ARB_ROUND_ROBIN_EN
      if (!empty[0] && !empty[1]) begin
        if (last_served == LAST_VC1) pop[0] = 1'b1;
        else                         pop[1] = 1'b1;
      end else if (!empty[0]) begin
        pop[0] = 1'b1;
      end else if (!empty[1]) begin
        pop[1] = 1'b1;
      end
`else
      if (!empty[0])      pop[0] = 1'b1;
      else if (!empty[1]) pop[1] = 1'b1;
`endif
    end
  end

  // A full FIFO still accepts a push when it is popped on the same edge.
  always_comb begin
    push     = '0;
    overflow = 1'b0;
    if (valid_in) begin
      if (push_vc) begin
        push[1]  = !full[1] || pop[1];
        overflow = full[1] && !pop[1];
      end else begin
        push[0]  = !full[0] || pop[0];
        overflow = full[0] && !pop[0];
      end
    end
  end

  for (genvar v = 0; v < 2; v++) begin : g_vc
    assign full[v]  = (count[v] == CW'(DEPTH));
    assign empty[v] = (count[v] == '0);
    assign head[v]  = mem[v][rd_ptr[v]];

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end else begin
        if (push[v]) wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop[v])  rd_ptr[v] <= rd_ptr[v] + 1'b1;
        count[v] <= count[v] + CW'(push[v]) - CW'(pop[v]);
      end
    end

    always_ff @(posedge clk) begin
      if (reset && push[v]) mem[v][wr_ptr[v]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_VC0 <= 1'b0;
      valid_VC1 <= 1'b0;
      data_out0 <= '0;
      data_out1 <= '0;
      error     <= 1'b0;
    end else begin
      valid_VC0 <= pop[0];
      valid_VC1 <= pop[1];
      if (pop[0]) data_out0 <= head[0];
      if (pop[1]) data_out1 <= head[1];
      if (overflow) error <= 1'b1;
    end
  end

`ifdef VC_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (!reset)      last_served <= LAST_VC1;
    else if (pop[0]) last_served <= LAST_VC0;
    else if (pop[1]) last_served <= LAST_VC1;
  end
`endif

  assign vc0_full  = full[0];
  assign vc1_full  = full[1];
  assign vc0_empty = empty[0];
  assign vc1_empty = empty[1];

endmodule

// File: tb/tb_vc_fifo_arb.sv
// Directed bench for vc_fifo_arb: per-VC data scoreboards plus an expected pop-order queue.
module tb_vc_fifo_arb;
  localparam int BW = 5;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [BW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          pause = 1'b1;
  logic          valid_VC0, valid_VC1;
  logic [BW-1:0] data_out0, data_out1;
  logic          vc0_full, vc1_full, vc0_empty, vc1_empty, error;

  int vectors = 0;
  int miscompares = 0;

  logic [BW-1:0] exp_q0[$];
  logic [BW-1:0] exp_q1[$];
  logic          exp_vc[$];

  vc_fifo_arb #(.BITNUMBER(BW), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .pause(pause),
    .valid_VC0(valid_VC0), .valid_VC1(valid_VC1), .data_out0(data_out0), .data_out1(data_out1),
    .vc0_full(vc0_full), .vc1_full(vc1_full), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are registered; sample them mid-cycle.
  always @(negedge clk) begin
    if (valid_VC0) begin
      check("vc1_quiet_on_pop0", 32'(valid_VC1), 32'd0);
      if (exp_q0.size() == 0) check("unexpected_pop0", 32'(valid_VC0), 32'd0);
      else check("data_out0", 32'(data_out0), 32'(exp_q0.pop_front()));
      if (exp_vc.size() != 0) check("pop_order", 32'(valid_VC1), 32'(exp_vc.pop_front()));
    end else if (valid_VC1) begin
      if (exp_q1.size() == 0) check("unexpected_pop1", 32'(valid_VC1), 32'd0);
      else check("data_out1", 32'(data_out1), 32'(exp_q1.pop_front()));
      if (exp_vc.size() != 0) check("pop_order", 32'(valid_VC1), 32'(exp_vc.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [BW-1:0] d, input bit accept);
    data_in  = d;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    if (accept) begin
      if (d[BW-1]) exp_q1.push_back(d);
      else         exp_q0.push_back(d);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    pause = 1'b0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    step();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    repeat (cycles) step();
    check("rst_valid", {30'd0, valid_VC1, valid_VC0}, 32'd0);
    check("rst_data0", 32'(data_out0), 32'd0);
    check("rst_data1", 32'(data_out1), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_flags", {28'd0, vc1_full, vc0_full, vc1_empty, vc0_empty}, 32'h3);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    // Reset held two cycles.
    do_reset(2);

    // One word per VC under pause, then release: VC0 first, then VC1.
    pause = 1'b1;
    push(5'h03, 1'b1);
    push(5'h13, 1'b1);
    check("both_nonempty", {30'd0, vc1_empty, vc0_empty}, 32'd0);
    exp_vc.push_back(1'b0);
    exp_vc.push_back(1'b1);
    drain(10);
    check("empty_after_drain", {30'd0, vc1_empty, vc0_empty}, 32'h3);

    // Push into an empty FIFO with pause=0 must not appear on the same edge.
    pause = 1'b0;
    exp_vc.push_back(1'b0);
    push(5'h05, 1'b1);
    check("no_bypass_valid", 32'(valid_VC0), 32'd0);
    check("no_bypass_occupied", 32'(vc0_empty), 32'd0);
    drain(10);

    // Overflow VC0: fifth push dropped, error sticky.
    pause = 1'b1;
    for (int i = 1; i <= 4; i++) push(BW'(i), 1'b1);
    check("vc0_full_at_4", 32'(vc0_full), 32'd1);
    check("no_error_at_4", 32'(error), 32'd0);
    push(5'h05, 1'b0);
    check("error_on_overflow", 32'(error), 32'd1);
    repeat (4) exp_vc.push_back(1'b0);
    drain(12);
    check("error_sticky", 32'(error), 32'd1);
    check("vc0_empty_after", 32'(vc0_empty), 32'd1);
    do_reset(1);

    // Both VCs full, then arbitration order.
    pause = 1'b1;
    for (int i = 0; i < 4; i++) push(BW'(i), 1'b1);
    for (int i = 0; i < 4; i++) push(BW'(16 + i), 1'b1);
    check("both_full", {30'd0, vc1_full, vc0_full}, 32'h3);
`ifdef VC_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) exp_vc.push_back(1'(i % 2));
`else
    for (int i = 0; i < 8; i++) exp_vc.push_back(1'(i / 4));
`endif
    drain(20);
    check("error_clear", 32'(error), 32'd0);

    // Push to full VC0 on the pop edge is accepted.
    pause = 1'b1;
    for (int i = 6; i <= 9; i++) push(BW'(i), 1'b1);
    check("vc0_full_again", 32'(vc0_full), 32'd1);
    repeat (5) exp_vc.push_back(1'b0);
    pause = 1'b0;
    push(5'h0A, 1'b1);
    check("push_on_pop_no_error", 32'(error), 32'd0);
    check("push_on_pop_still_full", 32'(vc0_full), 32'd1);
    drain(12);
    check("error_still_clear", 32'(error), 32'd0);

    // Mid-operation reset discards stored words and the cycle's push/pop.
    pause = 1'b1;
    push(5'h0B, 1'b0);
    push(5'h0C, 1'b0);
    push(5'h1D, 1'b0);
    reset    = 1'b0;
    pause    = 1'b0;
    data_in  = 5'h0E;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    check("midrst_empty", {30'd0, vc1_empty, vc0_empty}, 32'h3);
    check("midrst_valid", {30'd0, valid_VC1, valid_VC0}, 32'd0);
    reset = 1'b1;
    repeat (5) step();
    check("post_rst_empty", {30'd0, vc1_empty, vc0_empty}, 32'h3);
    check("post_rst_no_pops", {30'd0, valid_VC1, valid_VC0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
